// File: rtl/dccm_arb_pkg.sv
// dccm_arb_pkg: shared types and constants for the DCCM arbiter.
// Requester ids, arbiter FSM states and the requester count.
package dccm_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef enum logic {
    IDLE,
    RMW_MERGE
  } arb_state_e;

  localparam req_id_t REQ_LSU = 1'b0;
  localparam req_id_t REQ_DMA = 1'b1;

endpackage

// File: rtl/dccm_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with one-hot grant.
// Ports: clk, rst_n (sync, active-low), req[1:0], update_en -> gnt[1:0].
module rr_arb2
  import dccm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt
);

  req_id_t last_grant_q;
  req_id_t last_grant_d;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    unique case (1'b1)
      (req == 2'b11): gnt = last_grant_q ? 2'b01 : 2'b10;
      default:        gnt = req;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update_en && |gnt)
      last_grant_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant_q <= REQ_DMA;
    else
      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: shares the DCCM between LSU (port 0) and DMA (port 1).
// Ports: req_* / rsp_* per requester, mem_* to the DCCM. Macro DCCM_ARB_RMW_EN enables sub-word RMW stores.
module dccm_arbiter
  import dccm_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = WIDTH / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_we,
  input  logic [AW-1:0]      req_addr  [NUM_REQ],
  input  logic [WIDTH-1:0]   req_wdata [NUM_REQ],
  input  logic [BW-1:0]      req_be    [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata [NUM_REQ],
  output logic [AW-1:0]      mem_raddr,
  output logic               mem_rvalid_in,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_rvalid_out,
  output logic [AW-1:0]      mem_waddr,
  output logic               mem_wen,
  output logic [WIDTH-1:0]   mem_wdata
);

  arb_state_e state_q, state_d;
  req_id_t    rd_owner_q, rd_owner_d;
  logic       rd_pend_q, rd_pend_d;

  logic       arb_en;
  logic [1:0] gnt;
  req_id_t    win;
  logic       is_rd, is_drop, is_part, is_full;

`ifdef DCCM_ARB_RMW_EN
  logic [AW-1:0]    rmw_addr_q, rmw_addr_d;
  logic [WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [BW-1:0]    rmw_be_q, rmw_be_d;
`endif

  // Grants only happen out of reset and outside a merge cycle.
  assign arb_en = rst_n && (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .update_en (arb_en),
    .gnt       (gnt)
  );

  assign req_ready = gnt & {NUM_REQ{arb_en}};
  assign win       = gnt[1];

  // Mutually exclusive classification of the winning request.
  always_comb begin
    is_rd   = !req_we[win];
    is_drop = req_we[win] && (req_be[win] == '0);
`ifdef DCCM_ARB_RMW_EN
    is_part = req_we[win] && (req_be[win] != '0)
              && (req_be[win] != '1);
`else
    is_part = 1'b0;
`endif
    is_full = req_we[win] && !is_drop && !is_part;
  end

  always_comb begin
    state_d       = state_q;
    rd_owner_d    = rd_owner_q;
    rd_pend_d     = 1'b0;
    mem_rvalid_in = 1'b0;
    mem_raddr     = '0;
    mem_wen       = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = '0;
`ifdef DCCM_ARB_RMW_EN
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_be_d    = rmw_be_q;
`endif
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (|req_ready) begin
            unique case (1'b1)
              is_rd: begin
                mem_rvalid_in = 1'b1;
                mem_raddr     = req_addr[win];
                rd_pend_d     = 1'b1;
                rd_owner_d    = win;
              end
              is_part: begin
`ifdef DCCM_ARB_RMW_EN
                mem_rvalid_in = 1'b1;
                mem_raddr     = req_addr[win];
                rmw_addr_d    = req_addr[win];
                rmw_wdata_d   = req_wdata[win];
                rmw_be_d      = req_be[win];
                state_d       = RMW_MERGE;
`endif
              end
              is_full: begin
                mem_wen   = 1'b1;
                mem_waddr = req_addr[win];
                mem_wdata = req_wdata[win];
              end
              default: ;
            endcase
          end
        end
`ifdef DCCM_ARB_RMW_EN
        RMW_MERGE: begin
          mem_wen   = 1'b1;
          mem_waddr = rmw_addr_q;
          for (int b = 0; b < BW; b++)
            mem_wdata[b*8 +: 8] = rmw_be_q[b]
              ? rmw_wdata_q[b*8 +: 8]
              : mem_rdata[b*8 +: 8];
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Only normal reads return data; the RMW read never sets rd_pend.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_rdata[i] = '0;
    if (rst_n && rd_pend_q && mem_rvalid_out) begin
      rsp_valid[rd_owner_q] = 1'b1;
      rsp_rdata[rd_owner_q] = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_owner_q <= REQ_LSU;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

`ifdef DCCM_ARB_RMW_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end
`endif

endmodule

// File: tb/tb_dccm_arbiter.sv
// tb_dccm_arbiter: directed and randomized checks of dccm_arbiter.
// Includes a simple DCCM model and a word-level reference memory.
module tb_dccm_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BW    = 4;
`ifdef DCCM_ARB_RMW_EN
  localparam bit RMW_ON = 1'b1;
`else
  localparam bit RMW_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [AW-1:0] req_addr [2];
  logic [WIDTH-1:0] req_wdata [2];
  logic [WIDTH-1:0] rsp_rdata [2];
  logic [BW-1:0] req_be [2];
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic mem_rvalid_in, mem_rvalid_out, mem_wen;
  logic [WIDTH-1:0] mem_rdata, mem_wdata;

  logic pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [WIDTH-1:0] pre_data = '0;
  logic [WIDTH-1:0] dccm [DEPTH];
  logic [WIDTH-1:0] ref_mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dccm_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_raddr(mem_raddr), .mem_rvalid_in(mem_rvalid_in),
    .mem_rdata(mem_rdata), .mem_rvalid_out(mem_rvalid_out),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata)
  );

  // DCCM: registered read, full-word write, 1-cycle read valid.
  always @(posedge clk) begin
    if (mem_wen) dccm[mem_waddr] <= mem_wdata;
    if (pre_en) dccm[pre_addr] <= pre_data;
    mem_rvalid_out <= mem_rvalid_in;
    if (mem_rvalid_in) mem_rdata <= dccm[mem_raddr];
  end

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] wr_result(input logic [31:0] o,
      input logic [31:0] n, input logic [3:0] be);
    if (be == 4'h0) return o;
    return RMW_ON ? merge(o, n, be) : n;
  endfunction

  function automatic bit stalls(input logic we, input logic [3:0] be);
    return RMW_ON && we && be != 4'h0 && be != 4'hF;
  endfunction

  task automatic idle();
    req_valid = 2'b00;
  endtask

  task automatic set_req(input int p, input logic we,
      input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p] = a;
    req_wdata[p] = d;
    req_be[p] = be;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b0, 10'd5, 32'h0, 4'hF);
    set_req(1, 1'b1, 10'd6, 32'h55, 4'hF);
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", mem_wen); end
    checks++; if (mem_rvalid_in !== 1'b0) begin errors++; $display("FAIL rst_rvalid_in got %b exp 0", mem_rvalid_in); end
    checks++; if (mem_raddr !== '0 || mem_waddr !== '0) begin errors++; $display("FAIL rst_addr got %h/%h exp 0/0", mem_raddr, mem_waddr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_wdata); end
    checks++; if (rsp_rdata[0] !== '0 || rsp_rdata[1] !== '0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", rsp_rdata[0], rsp_rdata[1]); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    preload(10'd5, 32'hDEADBEEF);
    @(negedge clk);
    set_req(0, 1'b0, 10'd5, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sr_ready got %b exp 01", req_ready); end
    checks++; if (mem_rvalid_in !== 1'b1 || mem_raddr !== 10'd5) begin errors++; $display("FAIL sr_rd got %b@%0d exp 1@5", mem_rvalid_in, mem_raddr); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sr_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got %h exp deadbeef", rsp_rdata[0]); end
    checks++; if (rsp_rdata[1] !== '0) begin errors++; $display("FAIL sr_rdata1 got %h exp 0", rsp_rdata[1]); end
  endtask

  task automatic test_rr_tie();
    logic [1:0] exp_g, prev_g;
    logic [31:0] exp_d;
    do_reset();
    preload(10'd1, 32'hA1A1A1A1);
    preload(10'd2, 32'hB2B2B2B2);
    prev_g = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        set_req(0, 1'b0, 10'd1, 32'h0, 4'h0);
        set_req(1, 1'b0, 10'd2, 32'h0, 4'h0);
      end else idle();
      #1;
      exp_g = (k == 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_g); end
      if (k > 0) begin
        exp_d = prev_g[0] ? 32'hA1A1A1A1 : 32'hB2B2B2B2;
        checks++; if (rsp_valid !== prev_g) begin errors++; $display("FAIL rr_rsp_valid[%0d] got %b exp %b", k, rsp_valid, prev_g); end
        checks++; if (rsp_rdata[prev_g[1]] !== exp_d) begin errors++; $display("FAIL rr_rdata[%0d] got %h exp %h", k, rsp_rdata[prev_g[1]], exp_d); end
      end
      prev_g = exp_g;
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] exp_d;
    exp_d = RMW_ON ? 32'h11BB33DD : 32'hAABBCCDD;
    do_reset();
    preload(10'd3, 32'h11223344);
    @(negedge clk);
    set_req(1, 1'b1, 10'd3, 32'hAABBCCDD, 4'b0101);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ps_ready got %b exp 10", req_ready); end
`ifdef DCCM_ARB_RMW_EN
    checks++; if (mem_wen !== 1'b0 || mem_rvalid_in !== 1'b1) begin errors++; $display("FAIL ps_n got wen %b rd %b exp 0 1", mem_wen, mem_rvalid_in); end
    @(negedge clk);
    idle();
    set_req(0, 1'b0, 10'd3, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL ps_block got %b exp 00", req_ready); end
    checks++; if (mem_wen !== 1'b1 || mem_waddr !== 10'd3) begin errors++; $display("FAIL ps_wen got %b@%0d exp 1@3", mem_wen, mem_waddr); end
    checks++; if (mem_wdata !== exp_d) begin errors++; $display("FAIL ps_wdata got %h exp %h", mem_wdata, exp_d); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL ps_rsp got %b exp 00", rsp_valid); end
`else
    checks++; if (mem_wen !== 1'b1 || mem_waddr !== 10'd3) begin errors++; $display("FAIL ps_wen got %b@%0d exp 1@3", mem_wen, mem_waddr); end
    checks++; if (mem_wdata !== exp_d) begin errors++; $display("FAIL ps_wdata got %h exp %h", mem_wdata, exp_d); end
    @(negedge clk);
    idle();
    set_req(0, 1'b0, 10'd3, 32'h0, 4'h0);
`endif
    @(negedge clk);
    #1;
`ifdef DCCM_ARB_RMW_EN
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ps_regrant got %b exp 01", req_ready); end
    @(negedge clk);
    #1;
`endif
    idle();
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata[0] !== exp_d) begin errors++; $display("FAIL ps_readback got %b %h exp 01 %h", rsp_valid, rsp_rdata[0], exp_d); end
  endtask

  task automatic test_write_then_read();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 10'd7, 32'h1234, 4'hF);
    #1;
    checks++; if (req_ready !== 2'b01 || mem_wen !== 1'b1) begin errors++; $display("FAIL wr_n got %b %b exp 01 1", req_ready, mem_wen); end
    checks++; if (mem_waddr !== 10'd7 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL wr_data got %h@%0d exp 1234@7", mem_wdata, mem_waddr); end
    @(negedge clk);
    idle();
    set_req(1, 1'b0, 10'd7, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_rd_ready got %b exp 10", req_ready); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (rsp_valid !== 2'b10 || rsp_rdata[1] !== 32'h1234) begin errors++; $display("FAIL wr_rsp got %b %h exp 10 1234", rsp_valid, rsp_rdata[1]); end
    checks++; if (rsp_rdata[0] !== '0) begin errors++; $display("FAIL wr_rdata0 got %h exp 0", rsp_rdata[0]); end
  endtask

  task automatic test_be_zero();
    do_reset();
    preload(10'd8, 32'hCAFEF00D);
    @(negedge clk);
    set_req(0, 1'b1, 10'd8, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bz_ready got %b exp 01", req_ready); end
    checks++; if (mem_wen !== 1'b0 || mem_rvalid_in !== 1'b0) begin errors++; $display("FAIL bz_mem got %b %b exp 0 0", mem_wen, mem_rvalid_in); end
    @(negedge clk);
    idle();
    set_req(0, 1'b0, 10'd8, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bz_next got %b exp 01", req_ready); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (rsp_rdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL bz_data got %h exp cafef00d", rsp_rdata[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    preload(10'd6, 32'h66666666);
    @(negedge clk);
    set_req(1, 1'b0, 10'd6, 32'h0, 4'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rif_rsp got %b exp 00", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rif_rsp2 got %b exp 00", rsp_valid); end
`ifdef DCCM_ARB_RMW_EN
    preload(10'd4, 32'h0A0B0C0D);
    @(negedge clk);
    set_req(1, 1'b1, 10'd4, 32'hFFFFFFFF, 4'b0011);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_ready got %b exp 10", req_ready); end
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wen !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL rm_wen got %b %b exp 0 00", mem_wen, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b0, 10'd4, 32'h0, 4'h0);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_idle got %b exp 01", req_ready); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (rsp_rdata[0] !== 32'h0A0B0C0D) begin errors++; $display("FAIL rm_mem got %h exp 0a0b0c0d", rsp_rdata[0]); end
`endif
  endtask

  task automatic test_random();
    logic [1:0] pv, pwe, exp_g, exp_rv;
    logic [AW-1:0] pa [2];
    logic [31:0] pd [2];
    logic [31:0] exp_rd [2];
    logic [3:0] pbe [2];
    int last, w;
    bit blocked;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      preload(AW'(a), ref_mem[a]);
    end
    pv = 2'b00; pwe = 2'b00; last = 1; blocked = 1'b0;
    exp_rv = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 3) != 0) begin
          pv[p] = 1'b1;
          pwe[p] = $urandom_range(0, 1);
          pa[p] = AW'($urandom_range(0, 15));
          pd[p] = $urandom;
          case ($urandom_range(0, 3))
            0: pbe[p] = 4'h0;
            1: pbe[p] = 4'hF;
            default: pbe[p] = 4'($urandom_range(0, 15));
          endcase
        end
        req_valid[p] = pv[p];
        req_we[p] = pwe[p]; req_addr[p] = pa[p];
        req_wdata[p] = pd[p]; req_be[p] = pbe[p];
      end
      #1;
      exp_g = 2'b00;
      if (!blocked)
        exp_g = (pv == 2'b11) ? ((last == 0) ? 2'b10 : 2'b01) : pv;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_g); end
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid c%0d got %b exp %b", c, rsp_valid, exp_rv); end
      for (int p = 0; p < 2; p++) begin
        checks++; if (rsp_rdata[p] !== exp_rd[p]) begin errors++; $display("FAIL rnd_rdata%0d c%0d got %h exp %h", p, c, rsp_rdata[p], exp_rd[p]); end
      end
      exp_rv = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0; blocked = 1'b0;
      if (exp_g != 2'b00) begin
        w = exp_g[1] ? 1 : 0;
        last = w;
        pv[w] = 1'b0;
        if (!pwe[w]) begin
          exp_rv[w] = 1'b1;
          exp_rd[w] = ref_mem[pa[w][3:0]];
        end else begin
          ref_mem[pa[w][3:0]] = wr_result(ref_mem[pa[w][3:0]], pd[w], pbe[w]);
          blocked = stalls(pwe[w], pbe[w]);
        end
      end
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_drain got %b exp %b", rsp_valid, exp_rv); end
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      set_req(0, 1'b0, AW'(a), 32'h0, 4'h0);
      @(negedge clk);
      idle();
      #1;
      checks++; if (rsp_rdata[0] !== ref_mem[a]) begin errors++; $display("FAIL rnd_mem[%0d] got %h exp %h", a, rsp_rdata[0], ref_mem[a]); end
    end
  endtask

  initial begin
    req_valid = 2'b00; req_we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      req_addr[p] = '0; req_wdata[p] = '0; req_be[p] = '0;
    end
    test_reset();
    test_single_read();
    test_rr_tie();
    test_partial_store();
    test_write_then_read();
    test_be_zero();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
